// File: rtl/cla_subtractor_pipe_32bit_if.sv
// Handshake and data bundle for cla_subtractor_pipe_32bit.
// The operand side (valid_i/ready_o) and the result side (valid_o/ready_i)
// share one bundle, so the signal names match the block's port names.
interface cla_subtractor_pipe_32bit_if #(
  parameter int P_WIDTH = 32
);
  logic               valid_i;
  logic               ready_o;
  logic [P_WIDTH-1:0] a_i;
  logic [P_WIDTH-1:0] b_i;
  logic               borrow_i;
  logic               valid_o;
  logic               ready_i;
  logic [P_WIDTH-1:0] diff_o;
  logic               borrow_o;
  logic               overflow_o;

  modport master (
    output valid_i, a_i, b_i, borrow_i, ready_i,
    input  ready_o, valid_o, diff_o, borrow_o, overflow_o
  );

  modport slave (
    input  valid_i, a_i, b_i, borrow_i, ready_i,
    output ready_o, valid_o, diff_o, borrow_o, overflow_o
  );
endinterface

// File: rtl/cla_subtractor_pipe_32bit.sv
// Pipelined subtractor: diff = a + ~b + ~borrow_in, resolved P_SLICE bits per
// stage with a full carry-lookahead inside each slice. Operands are stored
// skewed: each stage keeps only the operand bits still to be processed and
// the result bits produced so far. Requires P_WIDTH/P_SLICE >= 2.
module cla_subtractor_pipe_32bit #(
  parameter int P_WIDTH = 32,
  parameter int P_SLICE = 8
) (
  input logic                        clk_i,
  input logic                        rst_ni,
  cla_subtractor_pipe_32bit_if.slave bus
);

  localparam int N     = P_WIDTH / P_SLICE;
  // Triangular packing: stage s (s < N-1) keeps P_WIDTH-(s+1)*P_SLICE operand
  // bits and (s+1)*P_SLICE result bits, concatenated in stage order.
  localparam int OPS_W = (N - 1) * P_WIDTH - (P_SLICE * (N - 1) * N) / 2;
  localparam int RES_W = (P_SLICE * (N - 1) * N) / 2;

  // One slice of lookahead addition: returns {carry_out, sum}.
  // Every carry is a flat sum of generate/propagate products.
  function automatic logic [P_SLICE:0] cla_slice(
    input logic [P_SLICE-1:0] a,
    input logic [P_SLICE-1:0] bn,
    input logic               cin
  );
    logic [P_SLICE-1:0] g;
    logic [P_SLICE-1:0] p;
    logic [P_SLICE:0]   c;
    logic               prop;
    g    = a & bn;
    p    = a ^ bn;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < P_SLICE; i++) begin
      c[i+1] = g[i];
      prop   = p[i];
      for (int unsigned k = 0; k < i; k++) begin
        c[i+1] = c[i+1] | (prop & g[i-1-k]);
        prop   = prop & p[i-1-k];
      end
      c[i+1] = c[i+1] | (prop & cin);
    end
    return {c[P_SLICE], p ^ c[P_SLICE-1:0]};
  endfunction

  logic               en;
  logic [N-1:0]       v_q;
  logic [N-2:0]       carry_q;
  logic [N-2:0]       carry_d;
  logic [OPS_W-1:0]   ops_a_q;
  logic [OPS_W-1:0]   ops_a_d;
  logic [OPS_W-1:0]   ops_b_q;
  logic [OPS_W-1:0]   ops_b_d;
  logic [RES_W-1:0]   res_q;
  logic [RES_W-1:0]   res_d;
  logic [P_WIDTH-1:0] fin_diff;
  logic               fin_borrow;
  logic               fin_ovf;
  logic [P_WIDTH-1:0] diff_q;
  logic               borrow_q;
  logic               ovf_q;

  assign en          = ~v_q[N-1] | bus.ready_i;
  assign bus.ready_o = en & rst_ni;

  for (genvar s = 0; s < N; s++) begin : g_stage
    logic [P_SLICE-1:0] a_sl;
    logic [P_SLICE-1:0] b_sl;
    logic               c_in;
    logic [P_SLICE:0]   sl;

    if (s == 0) begin : g_head
      assign a_sl = bus.a_i[P_SLICE-1:0];
      assign b_sl = bus.b_i[P_SLICE-1:0];
      assign c_in = ~bus.borrow_i;
      assign ops_a_d[0 +: P_WIDTH-P_SLICE] = bus.a_i[P_WIDTH-1:P_SLICE];
      assign ops_b_d[0 +: P_WIDTH-P_SLICE] = bus.b_i[P_WIDTH-1:P_SLICE];
      assign res_d[0 +: P_SLICE]           = sl[P_SLICE-1:0];
    end else begin : g_body
      localparam int OO_IN = (s - 1) * P_WIDTH - (P_SLICE * (s - 1) * s) / 2;
      localparam int RO_IN = (P_SLICE * (s - 1) * s) / 2;

      assign a_sl = ops_a_q[OO_IN +: P_SLICE];
      assign b_sl = ops_b_q[OO_IN +: P_SLICE];
      assign c_in = carry_q[s-1];

      if (s < N - 1) begin : g_mid
        localparam int OO_OUT = s * P_WIDTH - (P_SLICE * s * (s + 1)) / 2;
        localparam int OW_OUT = P_WIDTH - (s + 1) * P_SLICE;
        localparam int RO_OUT = (P_SLICE * s * (s + 1)) / 2;

        assign ops_a_d[OO_OUT +: OW_OUT] = ops_a_q[OO_IN+P_SLICE +: OW_OUT];
        assign ops_b_d[OO_OUT +: OW_OUT] = ops_b_q[OO_IN+P_SLICE +: OW_OUT];
        assign res_d[RO_OUT +: (s+1)*P_SLICE] =
          {sl[P_SLICE-1:0], res_q[RO_IN +: s*P_SLICE]};
      end else begin : g_tail
        assign fin_diff   = {sl[P_SLICE-1:0], res_q[RO_IN +: s*P_SLICE]};
        assign fin_borrow = ~sl[P_SLICE];
        assign fin_ovf    = (a_sl[P_SLICE-1] ^ b_sl[P_SLICE-1]) &
                            (sl[P_SLICE-1] ^ a_sl[P_SLICE-1]);
      end
    end

    assign sl = cla_slice(a_sl, ~b_sl, c_in);

    if (s < N - 1) begin : g_carry
      assign carry_d[s] = sl[P_SLICE];
    end
  end

  // Stage valids and the result registers: cleared by reset, move on en.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (en) begin
      v_q <= {v_q[N-2:0], bus.valid_i & bus.ready_o};
      // Result registers only load real beats, so a bubble never shows data.
      if (v_q[N-2]) begin
        diff_q   <= fin_diff;
        borrow_q <= fin_borrow;
        ovf_q    <= fin_ovf;
      end
    end
  end

  // Inner datapath registers: meaningful only where the matching valid is set.
  always_ff @(posedge clk_i) begin
    if (en) begin
      carry_q <= carry_d;
      ops_a_q <= ops_a_d;
      ops_b_q <= ops_b_d;
      res_q   <= res_d;
    end
  end

  assign bus.valid_o    = v_q[N-1];
  assign bus.diff_o     = diff_q;
  assign bus.borrow_o   = borrow_q;
  assign bus.overflow_o = ovf_q;

endmodule

// File: tb/tb_cla_subtractor_pipe_32bit.sv
// Bench for cla_subtractor_pipe_32bit: directed vectors with literal results,
// plus an arithmetic reference queue checked on every output transfer.
module tb_cla_subtractor_pipe_32bit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;

  always #5 clk = ~clk;

  cla_subtractor_pipe_32bit_if #(.P_WIDTH(W)) bus ();

  cla_subtractor_pipe_32bit #(.P_WIDTH(W), .P_SLICE(8)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bo;
    logic         ov;
  } res_t;

  // Reference: plain integer subtraction, unsigned and signed views.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    res_t r;
    longint unsigned ua, ub;
    longint sa, sb, sr;
    ua     = 64'(a);
    ub     = 64'(b);
    r.diff = a - b - W'(bi);
    r.bo   = (ua < ub + 64'(bi));
    sa     = longint'($signed(a));
    sb     = longint'($signed(b));
    sr     = sa - sb - longint'(64'(bi));
    r.ov   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return r;
  endfunction

  res_t         exp_q[$];
  res_t         e;
  int unsigned  out_cnt = 0;
  logic         have_prev = 1'b0;
  logic         prev_v, prev_r, prev_bo, prev_ov;
  logic [W-1:0] prev_d;

  // Monitor: outputs are stable at the falling edge; transfers happen at the next rising edge.
  always @(negedge clk) begin
    if (!rst_ni) begin
      exp_q.delete();
      have_prev = 1'b0;
    end else begin
      check("ready_rule", 64'(bus.ready_o), 64'(!bus.valid_o || bus.ready_i));
      if (have_prev && prev_v && !prev_r) begin
        check("stall_valid", 64'(bus.valid_o), 64'(prev_v));
        check("stall_diff", 64'(bus.diff_o), 64'(prev_d));
        check("stall_borrow", 64'(bus.borrow_o), 64'(prev_bo));
        check("stall_ovf", 64'(bus.overflow_o), 64'(prev_ov));
      end
      if (bus.valid_o && bus.ready_i) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL spurious_output: got beat diff 0x%0h, expected no beat", bus.diff_o);
        end else begin
          e = exp_q.pop_front();
          check("model_diff", 64'(bus.diff_o), 64'(e.diff));
          check("model_borrow", 64'(bus.borrow_o), 64'(e.bo));
          check("model_ovf", 64'(bus.overflow_o), 64'(e.ov));
          out_cnt++;
        end
      end
      if (bus.valid_i && bus.ready_o) exp_q.push_back(model(bus.a_i, bus.b_i, bus.borrow_i));
      prev_v    = bus.valid_o;
      prev_r    = bus.ready_i;
      prev_d    = bus.diff_o;
      prev_bo   = bus.borrow_o;
      prev_ov   = bus.overflow_o;
      have_prev = 1'b1;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge with valid_i still high.
  task automatic push_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    logic acc;
    acc          = 1'b0;
    bus.a_i      = a;
    bus.b_i      = b;
    bus.borrow_i = bi;
    bus.valid_i  = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus.ready_o;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_total++;
      $display("FAIL accept_timeout: got no ready_o, expected acceptance within 50 cycles");
    end
  endtask

  // One beat into an empty pipe with literal expected results and latency.
  task automatic single(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi, input logic [W-1:0] xd, input logic xbo, input logic xov);
    int unsigned lat;
    lat = 0;
    push_beat(a, b, bi);
    bus.valid_i = 1'b0;
    for (int unsigned i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (bus.valid_o) lat = i;
    end
    check({name, "_latency"}, 64'(lat), 64'd4);
    if (lat != 0) begin
      check({name, "_diff"}, 64'(bus.diff_o), 64'(xd));
      check({name, "_borrow"}, 64'(bus.borrow_o), 64'(xbo));
      check({name, "_ovf"}, 64'(bus.overflow_o), 64'(xov));
      @(posedge clk);
      #1;
      check({name, "_valid_drop"}, 64'(bus.valid_o), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned base;
    int unsigned vcount;
    logic        found;

    bus.valid_i  = 1'b0;
    bus.a_i      = '0;
    bus.b_i      = '0;
    bus.borrow_i = 1'b0;
    bus.ready_i  = 1'b1;
    rst_ni       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.valid_o), 64'd0);
    check("rst_diff", 64'(bus.diff_o), 64'd0);
    check("rst_borrow", 64'(bus.borrow_o), 64'd0);
    check("rst_ovf", 64'(bus.overflow_o), 64'd0);
    check("rst_ready", 64'(bus.ready_o), 64'd0);
    rst_ni = 1'b1;
    #1;
    check("post_rst_ready", 64'(bus.ready_o), 64'd1);
    check("post_rst_valid", 64'(bus.valid_o), 64'd0);
    @(posedge clk);
    #1;

    single("basic",     32'd5,          32'd3,          1'b0, 32'd2,          1'b0, 1'b0);
    single("underflow", 32'h0000_0000,  32'h0000_0001,  1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0);
    single("sovf",      32'h8000_0000,  32'h0000_0001,  1'b0, 32'h7FFF_FFFF,  1'b0, 1'b1);
    single("borrow_in", 32'h0000_0010,  32'h0000_000F,  1'b1, 32'h0000_0000,  1'b0, 1'b0);
    single("chain",     32'h0100_0000,  32'h0000_0001,  1'b0, 32'h00FF_FFFF,  1'b0, 1'b0);
    single("neg_ovf",   32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  1'b1, 1'b1);
    single("bin_edge",  32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'h7FFF_FFFF,  1'b1, 1'b0);

    // Backpressure: six back-to-back beats, three stalled edges after the first result.
    base = out_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) push_beat($urandom, $urandom, 1'($urandom_range(0, 1)));
        bus.valid_i = 1'b0;
      end
      begin
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
          @(negedge clk);
          if (bus.valid_o) found = 1'b1;
        end
        check("bp_valid_rise", 64'(found), 64'd1);
        @(posedge clk);
        #2;
        bus.ready_i = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_ready_low", 64'(bus.ready_o), 64'd0);
          check("bp_valid_held", 64'(bus.valid_o), 64'd1);
          @(posedge clk);
          #2;
        end
        bus.ready_i = 1'b1;
      end
    join
    for (int i = 0; i < 40 && (out_cnt - base) < 6; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("bp_beats_out", 64'(out_cnt - base), 64'd6);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset with three beats in flight: none may ever be emitted.
    base = out_cnt;
    push_beat(32'h0000_0100, 32'h0000_0001, 1'b0);
    push_beat(32'h0000_0200, 32'h0000_0002, 1'b0);
    push_beat(32'h0000_0300, 32'h0000_0003, 1'b1);
    bus.valid_i = 1'b0;
    rst_ni      = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_valid", 64'(bus.valid_o), 64'd0);
    check("mid_rst_diff", 64'(bus.diff_o), 64'd0);
    check("mid_rst_borrow", 64'(bus.borrow_o), 64'd0);
    check("mid_rst_ovf", 64'(bus.overflow_o), 64'd0);
    check("mid_rst_ready", 64'(bus.ready_o), 64'd0);
    rst_ni = 1'b1;
    #1;
    check("mid_rel_ready", 64'(bus.ready_o), 64'd1);
    check("mid_rel_valid", 64'(bus.valid_o), 64'd0);
    vcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.valid_o) vcount++;
    end
    check("mid_rst_no_valid", 64'(vcount), 64'd0);
    check("mid_rst_no_output", 64'(out_cnt - base), 64'd0);
    @(posedge clk);
    #1;
    single("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h0123_4567, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cla_subtractor_pipe_32bit.md
# cla_subtractor_pipe_32bit

Pipelined 32-bit subtractor that computes a − b − borrow_in. It is built from carry-lookahead slices that work on inverted subtrahend bits. The block sits beside the combinational CLA adder in the adder-comparison suite as its subtraction counterpart. Operands are accepted and results delivered over valid/ready handshakes, so a synthesis/timing run can compare a registered, sliced lookahead datapath against the flat adder.

## Interface
- P_WIDTH, 32, operand/result width; must be an integer multiple of P_SLICE.
- P_SLICE, 8, bits resolved per pipeline stage with one local CLA; stage count N = P_WIDTH/P_SLICE (4 by default).
- clk_i  input  1  single clock, all state on rising edge.
- rst_ni  input  1  synchronous, active-low reset.
- valid_i  input  1  operand beat valid.
- ready_o  output  1  block can accept a beat this cycle.
- a_i  input  P_WIDTH  minuend (unsigned or two's complement).
- b_i  input  P_WIDTH  subtrahend.
- borrow_i  input  1  incoming borrow; subtracted in addition to b_i.
- valid_o  output  1  result beat valid.
- ready_i  input  1  downstream accepts the result.
- diff_o  output  P_WIDTH  a_i − b_i − borrow_i, modulo 2^P_WIDTH.
- borrow_o  output  1  unsigned borrow out (result went below zero).
- overflow_o  output  1  signed overflow of the subtraction.

## Operation
- Arithmetic: diff = a + ~b + cin, where cin = ~borrow_i. Slice s takes bits [s·P_SLICE +: P_SLICE] and the carry from slice s−1. It uses generate g = a & ~b and propagate p = a ^ ~b, with full lookahead inside the slice.
  - borrow_o = ~carry out of the top slice.
  - overflow_o = (a[MSB] ≠ b[MSB]) && (diff[MSB] ≠ a[MSB]).
- Pipeline: N stages. Stage s computes slice s−1 and registers:
  - the lower result bits so far;
  - the inter-slice carry;
  - the still-unprocessed upper operand bits (skewed operand storage);
  - a stage valid bit.
- Stage N holds the full result, borrow_o and overflow_o. Outputs come directly from stage-N registers.
- Flow control: global advance enable en = ~valid_o | ready_i.
  - All stages shift together when en = 1 and hold when en = 0.
  - ready_o = en & rst_ni.
  - Bubbles (invalid stages) shift with the pipeline. They are not compressed.
- Input transfer: valid_i & ready_o at the rising edge.
- Output transfer: valid_o & ready_i at the rising edge.
- When the last stage is emptied with no new data behind it, valid_o drops the cycle after the transfer.
- Reset (rst_ni = 0 at an edge) applies to all stages:
  - all valid bits are cleared;
  - diff_o = 0, borrow_o = 0, overflow_o = 0, valid_o = 0.
  - ready_o = 0 while rst_ni is low.
- Reset mid-operation discards every in-flight beat. No partial result is ever presented.

## Timing
- Latency: a beat accepted at edge k appears with valid_o = 1 after edge k+N−1. This is N register stages, i.e. 4 cycles for the defaults, with no stall.
- Throughput: one beat per cycle while ready_i = 1.
- Stall: with valid_o = 1 and ready_i = 0, every stage and every output holds stable. ready_o = 0 in the same cycle, combinationally from ready_i and valid_o.
- Simultaneous output and input transfer in one cycle is legal. Both beats move and no beat is lost or duplicated.
- Handshake rules:
  - valid_o, diff_o, borrow_o and overflow_o must not change while valid_o = 1 and ready_i = 0.
  - Upstream may hold valid_i without ready_o; the block samples only on a transfer.
- Critical path is bounded to one P_SLICE-bit lookahead plus the carry register.
- First cycle after rst_ni rises: ready_o = 1 and valid_o = 0.

## Test plan
- Basic: a = 5, b = 3, borrow_i = 0, ready_i = 1.
  - Required response: diff_o = 2, borrow_o = 0, overflow_o = 0, valid_o exactly 4 cycles after acceptance.
- Underflow: a = 0x00000000, b = 0x00000001.
  - Required response: diff_o = 0xFFFFFFFF, borrow_o = 1, overflow_o = 0.
- Signed overflow: a = 0x80000000, b = 0x00000001.
  - Required response: diff_o = 0x7FFFFFFF, borrow_o = 0, overflow_o = 1.
- Borrow-in: a = 0x10, b = 0x0F, borrow_i = 1.
  - Required response: diff_o = 0x00000000, borrow_o = 0.
- Backpressure: 6 back-to-back random beats, with ready_i held low for 3 cycles once valid_o rises.
  - Required response: outputs stable during the stall, ready_o = 0 during the stall.
  - All 6 results match the reference model (a − b − borrow_i) in order, with no loss or duplication.
- Reset mid-stream: assert rst_ni = 0 for 1 edge with 3 beats in flight.
  - Required response: valid_o = 0 and outputs = 0 after that edge, none of the 3 beats ever emitted, and the next accepted beat emerges with normal 4-cycle latency.
